// File: rtl/vram_arbiter.sv
// Arbitrates a single-port character RAM between text-mode scan-out (absolute priority)
// and a host port served through a one-entry request buffer.
module vram_arbiter #(
    parameter int NCOL    = 40,
    parameter int NROW    = 30,
    parameter int HTOTAL  = 800,
    parameter int VTOTAL  = 525,
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 8,
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         x_px,
    input  logic [9:0]         y_px,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [DATA_W-1:0]  char_code,
    input  logic               host_valid,
    output logic               host_ready,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [DATA_W-1:0]  host_wdata,
    output logic [DATA_W-1:0]  host_rdata,
    output logic               host_rvalid,
    output logic [STALL_W-1:0] host_stall_cnt
);

    typedef enum logic {EMPTY, PENDING} host_state_t;

    host_state_t       state;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic [DATA_W-1:0] rdata_hold;
    logic              disp_pend;
    logic              host_rd_pend;

    logic [6:0]        mid_col;
    logic [9:0]        y_next;
    logic              mid_fetch;
    logic              line_fetch;
    logic              disp_fetch;
    logic [5:0]        disp_row;
    logic [6:0]        disp_col;
    logic [ADDR_W-1:0] disp_addr;
    logic              host_issue;

    // Fetch the next cell two pixels before the beam reaches it, so the
    // one-cycle RAM latency plus the char_code register line up with x[3:0]==0.
    assign mid_col    = {1'b0, x_px[9:4]} + 7'd1;
    assign mid_fetch  = (x_px[3:0] == 4'd14) && (y_px < 10'(NROW * 16)) && (mid_col < 7'(NCOL));
    assign y_next     = (y_px == 10'(VTOTAL - 1)) ? 10'd0 : y_px + 10'd1;
    assign line_fetch = (x_px == 10'(HTOTAL - 2)) && (y_next < 10'(NROW * 16));
    assign disp_fetch = mid_fetch || line_fetch;
    assign disp_row   = line_fetch ? y_next[9:4] : y_px[9:4];
    assign disp_col   = line_fetch ? 7'd0 : mid_col;
    assign disp_addr  = ADDR_W'(disp_row) * ADDR_W'(NCOL) + ADDR_W'(disp_col);

    assign host_issue = (state == PENDING) && !disp_fetch;

    assign mem_en      = !rst && (disp_fetch || host_issue);
    assign mem_we      = !rst && host_issue && buf_we;
    assign mem_addr    = disp_fetch ? disp_addr : buf_addr;
    assign mem_wdata   = buf_wdata;
    assign host_ready  = (state == EMPTY) && !rst;
    assign host_rvalid = host_rd_pend;
    assign host_rdata  = host_rd_pend ? mem_rdata : rdata_hold;

    // The owner pipe remembers who issued last cycle's read so returning data
    // is steered either into char_code or back to the host, never both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= EMPTY;
            buf_we         <= 1'b0;
            buf_addr       <= '0;
            buf_wdata      <= '0;
            char_code      <= '0;
            rdata_hold     <= '0;
            disp_pend      <= 1'b0;
            host_rd_pend   <= 1'b0;
            host_stall_cnt <= '0;
        end else begin
            disp_pend    <= disp_fetch;
            host_rd_pend <= host_issue && !buf_we;
            if (disp_pend)
                char_code <= mem_rdata;
            if (host_rd_pend)
                rdata_hold <= mem_rdata;
            case (state)
                EMPTY: begin
                    if (host_valid) begin
                        state     <= PENDING;
                        buf_we    <= host_we;
                        buf_addr  <= host_addr;
                        buf_wdata <= host_wdata;
                    end
                end
                PENDING: begin
                    if (!disp_fetch)
                        state <= EMPTY;
                    else if (host_stall_cnt != {STALL_W{1'b1}})
                        host_stall_cnt <= host_stall_cnt + 1'b1;
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
